// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC owner, single-outstanding fetch, decoder handshake
module ifu #(
  parameter int unsigned    CPU_WIDTH = 64,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 64'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [CPU_WIDTH-1:0] mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [63:0]          mem_rsp_data,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [31:0]          ins,
  output logic [CPU_WIDTH-1:0] ins_pc
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CPU_WIDTH-1:0]   pc_q, pc_d;
  logic                   discard_q, discard_d;
  logic [31:0]            ins_q, ins_d;
  logic [CPU_WIDTH-1:0]   ins_pc_q, ins_pc_d;
  logic [CPU_WIDTH-1:0]   redirect_target;

  // Redirect targets are forced to a word boundary; the low two bits carry no meaning.
  assign redirect_target = redirect_pc & ~CPU_WIDTH'(3);

  // Memory returns whole doublewords, so the request address drops the low three PC bits.
  assign mem_req_addr  = pc_q & ~CPU_WIDTH'(7);
  assign mem_req_valid = (state_q == ST_REQ);
  assign ins_valid     = (state_q == ST_HOLD);
  assign ins           = ins_q;
  assign ins_pc        = ins_pc_q;

  // Next-state logic: fetch sequencing, redirect handling and stale-response tracking.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    ins_d     = ins_q;
    ins_pc_d  = ins_pc_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        // A redirect always retargets the PC; if the old address was accepted in the
        // same cycle, its response is already in flight and must be thrown away.
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (mem_req_ready) begin
          state_d = ST_WAIT;
          if (redirect_valid) begin
            discard_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (mem_rsp_valid) begin
          if (discard_q || redirect_valid) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
            if (redirect_valid) begin
              pc_d = redirect_target;
            end
          end else begin
            ins_d    = pc_q[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
            ins_pc_d = pc_q;
            pc_d     = pc_q + CPU_WIDTH'(4);
            state_d  = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d      = redirect_target;
          discard_d = 1'b1;
        end
      end

      ST_HOLD: begin
        // Redirect wins over the handshake; a coincidentally accepted instruction is
        // wrong-path and is flushed downstream.
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = ST_REQ;
        end else if (ins_ready) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and output holding registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      ins_q     <= '0;
      ins_pc_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      ins_q     <= ins_d;
      ins_pc_q  <= ins_pc_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed self-checking bench for ifu
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins;
  logic [63:0] ins_pc;

  int checks = 0;
  int errors = 0;

  ifu #(.CPU_WIDTH(64), .RESET_PC(64'h8000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins           (ins),
    .ins_pc        (ins_pc)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid got %b want 0", ins_valid); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL reset_ins got %h want 0", ins); end
    checks++; if (ins_pc !== 64'h0) begin errors++; $display("FAIL reset_ins_pc got %h want 0", ins_pc); end
    rst = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_req_valid got %b want 0", mem_req_valid); end
    tick();
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b want 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL first_req_addr got %h want 80000000", mem_req_addr); end
  endtask

  task automatic test_sequential();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_req_valid got %b want 0", mem_req_valid); end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {32'h0020_0113, 32'h0010_0093};
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got %b want 1", ins_valid); end
    checks++; if (ins !== 32'h0010_0093) begin errors++; $display("FAIL seq1_ins got %h want 00100093", ins); end
    checks++; if (ins_pc !== 64'h8000_0000) begin errors++; $display("FAIL seq1_pc got %h want 80000000", ins_pc); end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL seq_req2_ins_valid got %b want 0", ins_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL seq_req2_addr got %h want 80000000", mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {32'h0020_0113, 32'h0010_0093};
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL seq2_valid got %b want 1", ins_valid); end
    checks++; if (ins !== 32'h0020_0113) begin errors++; $display("FAIL seq2_ins got %h want 00200113", ins); end
    checks++; if (ins_pc !== 64'h8000_0004) begin errors++; $display("FAIL seq2_pc got %h want 80000004", ins_pc); end
  endtask

  task automatic test_backpressure();
    ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid got %b want 1", i, ins_valid); end
      checks++; if (ins !== 32'h0020_0113) begin errors++; $display("FAIL stall%0d_ins got %h want 00200113", i, ins); end
      checks++; if (ins_pc !== 64'h8000_0004) begin errors++; $display("FAIL stall%0d_pc got %h want 80000004", i, ins_pc); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall%0d_req got %b want 0", i, mem_req_valid); end
    end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL resume_req got %b want 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0008) begin errors++; $display("FAIL resume_addr got %h want 80000008", mem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_idle%0d_req got %b want 0", i, mem_req_valid); end
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rw_idle%0d_ins_valid got %b want 0", i, ins_valid); end
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped_valid got %b want 0", ins_valid); end
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_next_req got %b want 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL rw_next_addr got %h want 80000100", mem_req_addr); end
  endtask

  task automatic test_redirect_coincident();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 64'h1111_1111_2222_2222;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0204;
    tick();
    mem_rsp_valid  = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rc_dropped_valid got %b want 0", ins_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0200) begin errors++; $display("FAIL rc_addr got %h want 80000200", mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {32'h0050_0293, 32'h0040_0213};
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (ins !== 32'h0050_0293) begin errors++; $display("FAIL rc_ins got %h want 00500293", ins); end
    checks++; if (ins_pc !== 64'h8000_0204) begin errors++; $display("FAIL rc_pc got %h want 80000204", ins_pc); end
  endtask

  task automatic test_redirect_hold();
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL rh_pre_valid got %b want 1", ins_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0010;
    ins_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    ins_ready      = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %b want 0", ins_valid); end
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rh_req got %b want 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0010) begin errors++; $display("FAIL rh_addr got %h want 80000010", mem_req_addr); end
  endtask

  task automatic test_redirect_req_stall();
    mem_req_ready = 1'b0;
    tick();
    checks++; if (mem_req_addr !== 64'h8000_0010) begin errors++; $display("FAIL rs_stall1_addr got %h want 80000010", mem_req_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0040;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rs_req got %b want 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0040) begin errors++; $display("FAIL rs_addr got %h want 80000040", mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {32'h0000_0013, 32'h0030_0193};
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (ins !== 32'h0030_0193) begin errors++; $display("FAIL rs_ins got %h want 00300193", ins); end
    checks++; if (ins_pc !== 64'h8000_0040) begin errors++; $display("FAIL rs_pc got %h want 80000040", ins_pc); end
  endtask

  // Low redirect bits are ignored and the PC wraps past the top of the address space.
  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL wrap_addr got %h want fffffffffffffff8", mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {32'hABCD_0013, 32'h1234_0013};
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (ins !== 32'hABCD_0013) begin errors++; $display("FAIL wrap_ins got %h want abcd0013", ins); end
    checks++; if (ins_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffffffffffc", ins_pc); end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    checks++; if (mem_req_addr !== 64'h0) begin errors++; $display("FAIL wrap_next_addr got %h want 0", mem_req_addr); end
  endtask

  task automatic test_reset_midflight();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h5555_5555_5555_5555;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", ins_valid); end
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL mr_req got %b want 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL mr_addr got %h want 80000000", mem_req_addr); end
    tick();
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL mr_ins got %h want 0", ins); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_redirect_hold();
    test_redirect_req_stall();
    test_wrap();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
